// File: rtl/box_motion_pkg.sv
// Shared types and default geometry for the bouncing-box motion engine.
package box_motion_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    STEP_X,
    STEP_Y,
    COMMIT
  } state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_BOX_SIZE = 200;
  localparam int DEF_POS_W    = 10;
  localparam int DEF_SPEED_W  = 4;

endpackage

// File: rtl/box_motion_ctrl_if.sv
// Frame-timing inputs and box position/status outputs of the motion engine.
interface box_motion_ctrl_if
  import box_motion_pkg::*;
#(
  parameter int POS_W   = DEF_POS_W,
  parameter int SPEED_W = DEF_SPEED_W
);
  logic               vsync;
  logic [SPEED_W-1:0] speed;
  logic               pause;
  logic [POS_W-1:0]   box_x;
  logic [POS_W-1:0]   box_y;
  logic               dir_x;
  logic               dir_y;
  logic               bounce;
  logic               corner;
  logic [7:0]         bounce_count;

  modport master (
    output vsync, speed, pause,
    input  box_x, box_y, dir_x, dir_y, bounce, corner, bounce_count
  );

  modport slave (
    input  vsync, speed, pause,
    output box_x, box_y, dir_x, dir_y, bounce, corner, bounce_count
  );
endinterface

// File: rtl/box_axis_step.sv
// One-axis position step with reflection at 0 and at max_pos (combinational).
module box_axis_step
  import box_motion_pkg::*;
#(
  parameter int POS_W   = DEF_POS_W,
  parameter int SPEED_W = DEF_SPEED_W
) (
  input  logic [POS_W-1:0]   pos,
  input  logic               dir,
  input  logic [SPEED_W-1:0] spd,
  input  logic [POS_W:0]     max_pos,
  output logic [POS_W-1:0]   next_pos,
  output logic               next_dir,
  output logic               hit
);

  logic [POS_W:0] pos_w;
  logic [POS_W:0] spd_w;
  logic [POS_W:0] sum_w;

  always_comb begin
    pos_w = {1'b0, pos};
    spd_w = '0;
    spd_w[SPEED_W-1:0] = spd;
    // One extra bit keeps pos + spd from wrapping before the limit compare.
    sum_w = pos_w + spd_w;

    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;

    if (!dir) begin
      if (sum_w >= max_pos) begin
        next_pos = max_pos[POS_W-1:0];
        next_dir = 1'b1;
        hit      = 1'b1;
      end else begin
        next_pos = sum_w[POS_W-1:0];
      end
    end else begin
      if (pos_w <= spd_w) begin
        next_pos = '0;
        next_dir = 1'b0;
        hit      = 1'b1;
      end else begin
        next_pos = pos - spd_w[POS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/box_motion_ctrl.sv
// Per-frame box motion: steps x then y into shadows on a vsync rise, then
// commits both axes together so the compositor never sees a split update.
module box_motion_ctrl
  import box_motion_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int BOX_SIZE = DEF_BOX_SIZE,
  parameter int POS_W    = DEF_POS_W,
  parameter int SPEED_W  = DEF_SPEED_W
) (
  input  logic              clk,
  input  logic              reset,
  box_motion_ctrl_if.slave  bus
);

  localparam logic [POS_W:0] MAX_X = (POS_W+1)'(H_ACTIVE - BOX_SIZE);
  localparam logic [POS_W:0] MAX_Y = (POS_W+1)'(V_ACTIVE - BOX_SIZE);

  state_e             state_q, state_d;
  logic               vsync_prev_q, vsync_prev_d;
  logic [POS_W-1:0]   box_x_q, box_x_d;
  logic [POS_W-1:0]   box_y_q, box_y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic               bounce_q, bounce_d;
  logic               corner_q, corner_d;
  logic [7:0]         bounce_count_q, bounce_count_d;

  logic [SPEED_W-1:0] spd_q, spd_d;
  logic [POS_W-1:0]   nx_q, nx_d;
  logic [POS_W-1:0]   ny_q, ny_d;
  logic               ndx_q, ndx_d;
  logic               ndy_q, ndy_d;
  logic               hx_q, hx_d;
  logic               hy_q, hy_d;

  logic               frame_edge;
  logic [POS_W-1:0]   x_next, y_next;
  logic               x_dir_next, y_dir_next;
  logic               x_hit, y_hit;

  box_axis_step #(.POS_W(POS_W), .SPEED_W(SPEED_W)) u_step_x (
    .pos      (box_x_q),
    .dir      (dir_x_q),
    .spd      (spd_q),
    .max_pos  (MAX_X),
    .next_pos (x_next),
    .next_dir (x_dir_next),
    .hit      (x_hit)
  );

  box_axis_step #(.POS_W(POS_W), .SPEED_W(SPEED_W)) u_step_y (
    .pos      (box_y_q),
    .dir      (dir_y_q),
    .spd      (spd_q),
    .max_pos  (MAX_Y),
    .next_pos (y_next),
    .next_dir (y_dir_next),
    .hit      (y_hit)
  );

  assign frame_edge = bus.vsync & ~vsync_prev_q;

  always_comb begin
    state_d        = state_q;
    vsync_prev_d   = bus.vsync;
    box_x_d        = box_x_q;
    box_y_d        = box_y_q;
    dir_x_d        = dir_x_q;
    dir_y_d        = dir_y_q;
    bounce_d       = 1'b0;
    corner_d       = 1'b0;
    bounce_count_d = bounce_count_q;
    spd_d          = spd_q;
    nx_d           = nx_q;
    ny_d           = ny_q;
    ndx_d          = ndx_q;
    ndy_d          = ndy_q;
    hx_d           = hx_q;
    hy_d           = hy_q;

    case (state_q)
      WAIT_FRAME: begin
        // Paused or zero-speed frames are dropped entirely, pulses included.
        if (frame_edge && !bus.pause && (bus.speed != '0)) begin
          spd_d   = bus.speed;
          state_d = STEP_X;
        end
      end
      STEP_X: begin
        nx_d    = x_next;
        ndx_d   = x_dir_next;
        hx_d    = x_hit;
        state_d = STEP_Y;
      end
      STEP_Y: begin
        ny_d    = y_next;
        ndy_d   = y_dir_next;
        hy_d    = y_hit;
        state_d = COMMIT;
      end
      COMMIT: begin
        box_x_d        = nx_q;
        box_y_d        = ny_q;
        dir_x_d        = ndx_q;
        dir_y_d        = ndy_q;
        bounce_d       = hx_q | hy_q;
        corner_d       = hx_q & hy_q;
        bounce_count_d = bounce_count_q + 8'(hx_q | hy_q);
        state_d        = WAIT_FRAME;
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  // vsync_prev resets high so vsync already high at release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_FRAME;
      vsync_prev_q   <= 1'b1;
      box_x_q        <= '0;
      box_y_q        <= '0;
      dir_x_q        <= 1'b0;
      dir_y_q        <= 1'b0;
      bounce_q       <= 1'b0;
      corner_q       <= 1'b0;
      bounce_count_q <= '0;
    end else begin
      state_q        <= state_d;
      vsync_prev_q   <= vsync_prev_d;
      box_x_q        <= box_x_d;
      box_y_q        <= box_y_d;
      dir_x_q        <= dir_x_d;
      dir_y_q        <= dir_y_d;
      bounce_q       <= bounce_d;
      corner_q       <= corner_d;
      bounce_count_q <= bounce_count_d;
    end
  end

  // Shadows and latched speed are only read after being written this frame.
  always_ff @(posedge clk) begin
    spd_q <= spd_d;
    nx_q  <= nx_d;
    ny_q  <= ny_d;
    ndx_q <= ndx_d;
    ndy_q <= ndy_d;
    hx_q  <= hx_d;
    hy_q  <= hy_d;
  end

  assign bus.box_x        = box_x_q;
  assign bus.box_y        = box_y_q;
  assign bus.dir_x        = dir_x_q;
  assign bus.dir_y        = dir_y_q;
  assign bus.bounce       = bounce_q;
  assign bus.corner       = corner_q;
  assign bus.bounce_count = bounce_count_q;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Bench for box_motion_ctrl: a 640x480 and a 480x480 instance share stimulus
// and are compared every cycle against a frame-level reference model.
module tb_box_motion_ctrl;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       pause;
  logic [3:0] speed;

  int total = 0;
  int bad   = 0;

  box_motion_ctrl_if #(.POS_W(10), .SPEED_W(4)) ifa ();
  box_motion_ctrl_if #(.POS_W(10), .SPEED_W(4)) ifb ();

  assign ifa.vsync = vsync;
  assign ifa.pause = pause;
  assign ifa.speed = speed;
  assign ifb.vsync = vsync;
  assign ifb.pause = pause;
  assign ifb.speed = speed;

  box_motion_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX_SIZE(200), .POS_W(10), .SPEED_W(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  box_motion_ctrl #(.H_ACTIVE(480), .V_ACTIVE(480), .BOX_SIZE(200), .POS_W(10), .SPEED_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUTs at the most recent rising edge.
  logic       s_vsync, s_pause;
  logic [3:0] s_speed;
  always @(posedge clk) begin
    s_vsync <= vsync;
    s_pause <= pause;
    s_speed <= speed;
  end

  // Frame-level model: an accepted frame edge applies its step three edges later.
  int mx[2] = '{440, 280};
  int my[2] = '{280, 280};
  int ex[2], ey[2], edx[2], edy[2], eb[2], ec[2], ecnt[2];
  int px[2], py[2], pdx[2], pdy[2], pb[2], pc[2];
  int busy, vprev;
  int bounces_a, corners_a, corners_b;

  function automatic void axis(input int pos, input int dir, input int spd, input int lim,
                               output int np, output int nd, output int h);
    np = pos; nd = dir; h = 0;
    if (dir == 0) begin
      if (pos + spd >= lim) begin np = lim; nd = 1; h = 1; end
      else np = pos + spd;
    end else begin
      if (pos <= spd) begin np = 0; nd = 0; h = 1; end
      else np = pos - spd;
    end
  endfunction

  initial begin
    busy = 0; vprev = 1;
    bounces_a = 0; corners_a = 0; corners_b = 0;
    for (int i = 0; i < 2; i++) begin
      ex[i] = 0; ey[i] = 0; edx[i] = 0; edy[i] = 0; eb[i] = 0; ec[i] = 0; ecnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0; vprev = 1;
        for (int i = 0; i < 2; i++) begin
          ex[i] = 0; ey[i] = 0; edx[i] = 0; edy[i] = 0; eb[i] = 0; ec[i] = 0; ecnt[i] = 0;
        end
      end else begin
        int hx, hy;
        for (int i = 0; i < 2; i++) begin eb[i] = 0; ec[i] = 0; end
        if (busy > 0) begin
          busy--;
          if (busy == 0) begin
            for (int i = 0; i < 2; i++) begin
              ex[i] = px[i]; ey[i] = py[i]; edx[i] = pdx[i]; edy[i] = pdy[i];
              eb[i] = pb[i]; ec[i] = pc[i];
              ecnt[i] = (ecnt[i] + pb[i]) % 256;
            end
          end
        end else if (s_vsync && !vprev && !s_pause && s_speed != 0) begin
          for (int i = 0; i < 2; i++) begin
            axis(ex[i], edx[i], int'(s_speed), mx[i], px[i], pdx[i], hx);
            axis(ey[i], edy[i], int'(s_speed), my[i], py[i], pdy[i], hy);
            pb[i] = hx | hy;
            pc[i] = hx & hy;
          end
          busy = 3;
        end
        vprev = int'(s_vsync);

        check("a_box_x", int'(ifa.box_x), ex[0]);
        check("a_box_y", int'(ifa.box_y), ey[0]);
        check("a_dir_x", int'(ifa.dir_x), edx[0]);
        check("a_dir_y", int'(ifa.dir_y), edy[0]);
        check("a_bounce", int'(ifa.bounce), eb[0]);
        check("a_corner", int'(ifa.corner), ec[0]);
        check("a_count", int'(ifa.bounce_count), ecnt[0]);
        check("b_box_x", int'(ifb.box_x), ex[1]);
        check("b_box_y", int'(ifb.box_y), ey[1]);
        check("b_dir_x", int'(ifb.dir_x), edx[1]);
        check("b_dir_y", int'(ifb.dir_y), edy[1]);
        check("b_bounce", int'(ifb.bounce), eb[1]);
        check("b_corner", int'(ifb.corner), ec[1]);
        check("b_count", int'(ifb.bounce_count), ecnt[1]);
        bounces_a += int'(ifa.bounce);
        corners_a += int'(ifa.corner);
        corners_b += int'(ifb.corner);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic frame(input int spd, input int p);
    @(negedge clk);
    speed = 4'(spd); pause = p[0]; vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Speed changes to spd1 after the accepting edge, before the update finishes.
  task automatic frame_chg(input int spd0, input int spd1);
    @(negedge clk);
    speed = 4'(spd0); pause = 1'b0; vsync = 1'b1;
    @(negedge clk);
    speed = 4'(spd1);
    @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vsync = 1'b0; pause = 1'b0; speed = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_box_x", int'(ifa.box_x), 0);
    check("rst_box_y", int'(ifa.box_y), 0);
    check("rst_dirs", int'({ifa.dir_x, ifa.dir_y}), 0);
    check("rst_count", int'(ifa.bounce_count), 0);
    #1 reset = 1'b0;

    // Single frame at speed 3: visible exactly at k+3, not at k+2.
    @(negedge clk);
    speed = 4'd3; vsync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("lat_k2_x", int'(ifa.box_x), 0);
    check("lat_k2_y", int'(ifa.box_y), 0);
    @(posedge clk);
    #1;
    check("lat_k3_x", int'(ifa.box_x), 3);
    check("lat_k3_y", int'(ifa.box_y), 3);
    check("lat_k3_bounce", int'(ifa.bounce), 0);
    @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);

    // 88 frames at speed 5 from reset.
    do_reset();
    bounces_a = 0; corners_a = 0; corners_b = 0;
    for (int i = 0; i < 87; i++) begin
      frame(5, 0);
      if (i == 55) begin
        check("f56_a_y", int'(ifa.box_y), 280);
        check("f56_a_dir_y", int'(ifa.dir_y), 1);
        check("f56_a_count", int'(ifa.bounce_count), 1);
        check("f56_b_x", int'(ifb.box_x), 280);
        check("f56_b_y", int'(ifb.box_y), 280);
        check("f56_b_dirs", int'({ifb.dir_x, ifb.dir_y}), 3);
        check("f56_b_count", int'(ifb.bounce_count), 1);
        check("f56_b_corners", corners_b, 1);
      end
    end
    check("f87_a_x", int'(ifa.box_x), 435);
    check("f87_a_y", int'(ifa.box_y), 125);
    frame(5, 0);
    check("f88_a_x", int'(ifa.box_x), 440);
    check("f88_a_dir_x", int'(ifa.dir_x), 1);
    check("f88_a_y", int'(ifa.box_y), 120);
    check("f88_a_count", int'(ifa.bounce_count), 2);
    check("f88_a_bounce_cycles", bounces_a, 2);
    check("f88_a_corners", corners_a, 0);
    check("f88_b_count", int'(ifb.bounce_count), 1);

    // Paused frames, then zero-speed frames, then resume.
    for (int i = 0; i < 10; i++) frame(5, 1);
    for (int i = 0; i < 10; i++) frame(0, 0);
    check("hold_a_x", int'(ifa.box_x), 440);
    check("hold_a_y", int'(ifa.box_y), 120);
    check("hold_a_count", int'(ifa.bounce_count), 2);
    frame(5, 0);
    check("resume_a_x", int'(ifa.box_x), 435);
    check("resume_a_y", int'(ifa.box_y), 115);

    // Walk x back down to 4, then reflect at 0 with a mid-update speed change.
    for (int i = 0; i < 28; i++) frame(15, 0);
    check("back_a_x15", int'(ifa.box_x), 15);
    check("back_a_count", int'(ifa.bounce_count), 4);
    frame(11, 0);
    check("back_a_x4", int'(ifa.box_x), 4);
    check("back_a_dir_x", int'(ifa.dir_x), 1);
    frame_chg(5, 15);
    check("refl0_a_x", int'(ifa.box_x), 0);
    check("refl0_a_dir_x", int'(ifa.dir_x), 0);
    check("refl0_a_count", int'(ifa.bounce_count), 5);
    frame_chg(5, 15);
    check("spdlatch_a_x", int'(ifa.box_x), 5);

    // Reset in the middle of an update, released with vsync still high.
    @(negedge clk);
    speed = 4'd5; vsync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_a_x", int'(ifa.box_x), 0);
    check("midrst_a_dirs", int'({ifa.dir_x, ifa.dir_y}), 0);
    check("midrst_a_count", int'(ifa.bounce_count), 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    check("vsync_hi_a_x", int'(ifa.box_x), 0);
    vsync = 1'b0;
    frame(5, 0);
    check("post_rst_a_x", int'(ifa.box_x), 5);
    check("post_rst_a_y", int'(ifa.box_y), 5);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
